// File: rtl/keynsham_bus_arbiter.sv
// rtl/keynsham_bus_arbiter.sv - two-master round-robin arbiter in front of the peripheral bus
// Optional grant timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module keynsham_bus_arbiter #(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_access,
    input  logic [29:0] m0_addr,
    input  logic [31:0] m0_wr_val,
    input  logic        m0_wr_en,
    input  logic [3:0]  m0_bytesel,
    output logic        m0_ack,
    output logic        m0_error,
    output logic [31:0] m0_data,
    input  logic        m1_access,
    input  logic [29:0] m1_addr,
    input  logic [31:0] m1_wr_val,
    input  logic        m1_wr_en,
    input  logic [3:0]  m1_bytesel,
    output logic        m1_ack,
    output logic        m1_error,
    output logic [31:0] m1_data,
    output logic        bus_access,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wr_val,
    output logic        bus_wr_en,
    output logic [3:0]  bus_bytesel,
    input  logic        bus_ack,
    input  logic        bus_error,
    input  logic [31:0] bus_data
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state;
    state_t state_next;
    logic   last;
    logic   last_next;
    logic   gnt0;
    logic   gnt1;
    logic   resp;
    logic   tmo;

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);
    assign resp = bus_ack | bus_error;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // A real slave response in the terminal cycle takes priority over the forced error.
    assign tmo = (state != IDLE) && !resp && (tmo_cnt == 16'(timeout_cycles - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if (state != IDLE) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout;

    assign tmo            = 1'b0;
    assign unused_timeout = |timeout_cycles;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    // Completion hands straight over to a waiting master so there is no idle bubble.
    always_comb begin
        state_next = state;
        last_next  = last;
        case (state)
            IDLE: begin
                if (m0_access && m1_access) begin
                    state_next = last ? GNT0 : GNT1;
                end else if (m0_access) begin
                    state_next = GNT0;
                end else if (m1_access) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (resp || tmo) begin
                    last_next  = 1'b0;
                    state_next = m1_access ? GNT1 : IDLE;
                end else if (!m0_access) begin
                    last_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            GNT1: begin
                if (resp || tmo) begin
                    last_next  = 1'b1;
                    state_next = m0_access ? GNT0 : IDLE;
                end else if (!m1_access) begin
                    last_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_access  = 1'b0;
        bus_addr    = '0;
        bus_wr_val  = '0;
        bus_wr_en   = 1'b0;
        bus_bytesel = '0;
        if (gnt0) begin
            bus_access  = m0_access;
            bus_addr    = m0_addr;
            bus_wr_val  = m0_wr_val;
            bus_wr_en   = m0_wr_en;
            bus_bytesel = m0_bytesel;
        end else if (gnt1) begin
            bus_access  = m1_access;
            bus_addr    = m1_addr;
            bus_wr_val  = m1_wr_val;
            bus_wr_en   = m1_wr_en;
            bus_bytesel = m1_bytesel;
        end
    end

    assign m0_ack   = bus_ack & gnt0;
    assign m0_error = (bus_error | tmo) & gnt0;
    assign m0_data  = (gnt0 && bus_ack) ? bus_data : 32'd0;
    assign m1_ack   = bus_ack & gnt1;
    assign m1_error = (bus_error | tmo) & gnt1;
    assign m1_data  = (gnt1 && bus_ack) ? bus_data : 32'd0;

endmodule

// File: tb/tb_keynsham_bus_arbiter.sv
// tb/tb_keynsham_bus_arbiter.sv - scoreboard testbench for keynsham_bus_arbiter
module tb_keynsham_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_access, m0_wr_en, m1_access, m1_wr_en;
    logic [29:0] m0_addr, m1_addr;
    logic [31:0] m0_wr_val, m1_wr_val;
    logic [3:0]  m0_bytesel, m1_bytesel;
    logic        m0_ack, m0_error, m1_ack, m1_error;
    logic [31:0] m0_data, m1_data;
    logic        bus_access, bus_wr_en, bus_ack, bus_error;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_val, bus_data;
    logic [3:0]  bus_bytesel;

    always #5 clk = ~clk;

    keynsham_bus_arbiter #(.timeout_cycles(8)) dut (
        .clk(clk), .rst(rst),
        .m0_access(m0_access), .m0_addr(m0_addr), .m0_wr_val(m0_wr_val),
        .m0_wr_en(m0_wr_en), .m0_bytesel(m0_bytesel),
        .m0_ack(m0_ack), .m0_error(m0_error), .m0_data(m0_data),
        .m1_access(m1_access), .m1_addr(m1_addr), .m1_wr_val(m1_wr_val),
        .m1_wr_en(m1_wr_en), .m1_bytesel(m1_bytesel),
        .m1_ack(m1_ack), .m1_error(m1_error), .m1_data(m1_data),
        .bus_access(bus_access), .bus_addr(bus_addr), .bus_wr_val(bus_wr_val),
        .bus_wr_en(bus_wr_en), .bus_bytesel(bus_bytesel),
        .bus_ack(bus_ack), .bus_error(bus_error), .bus_data(bus_data)
    );

    typedef struct packed {
        logic        a0;
        logic        e0;
        logic [31:0] d0;
        logic        a1;
        logic        e1;
        logic [31:0] d1;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    // Every cycle the master-side responses must equal the queued expectation, or all zero.
    always @(negedge clk) begin
        if (mon_en) begin
            resp_t got;
            resp_t want;
            got  = {m0_ack, m0_error, m0_data, m1_ack, m1_error, m1_data};
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL resp @%0t: got %h expected %h", $time, got, want);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input int m, input bit err, input logic [31:0] d);
        resp_t r;
        r = '0;
        if (m == 0) begin
            r.a0 = !err;
            r.e0 = err;
            r.d0 = err ? 32'd0 : d;
        end else begin
            r.a1 = !err;
            r.e1 = err;
            r.d1 = err ? 32'd0 : d;
        end
        exp_q.push_back(r);
    endtask

    task automatic slave_drive(input int m, input bit err, input logic [31:0] d);
        bus_ack   = !err;
        bus_error = err;
        bus_data  = d;
        expect_resp(m, err, d);
    endtask

    task automatic slave_idle;
        bus_ack   = 1'b0;
        bus_error = 1'b0;
        bus_data  = '0;
    endtask

    task automatic idle_masters;
        m0_access = 0; m0_addr = '0; m0_wr_val = '0; m0_wr_en = 0; m0_bytesel = '0;
        m1_access = 0; m1_addr = '0; m1_wr_val = '0; m1_wr_en = 0; m1_bytesel = '0;
    endtask

    task automatic do_reset;
        idle_masters();
        slave_idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        m0_access = 1; m0_addr = 30'h3FF; m0_wr_val = '1; m0_wr_en = 1; m0_bytesel = 4'hF;
        m1_access = 1; m1_addr = 30'h155; m1_wr_val = '1; m1_wr_en = 1; m1_bytesel = 4'hF;
        bus_ack = 1; bus_error = 1; bus_data = 32'hFFFF_FFFF;
        tick();
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected 0",
                     {bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel});
        end
        tick();
        idle_masters();
        slave_idle();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        m0_addr = 30'h10; m0_wr_en = 0; m0_bytesel = 4'hF; m0_access = 1;
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b0) begin
            n_fail++; $display("FAIL read_latency: bus_access=%b expected 0", bus_access);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b1 || bus_addr !== 30'h10 || bus_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL read_grant: access=%b addr=%h wr_en=%b expected 1/10/0",
                     bus_access, bus_addr, bus_wr_en);
        end
        tick();
        tick();
        slave_drive(0, 0, 32'hDEAD_BEEF);
        @(negedge clk);
        tick();
        slave_idle();
        m0_access = 0;
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b0) begin
            n_fail++; $display("FAIL read_release: bus_access=%b expected 0", bus_access);
        end
        tick();
    endtask

    task automatic test_simultaneous;
        do_reset();
        m0_addr = 30'h100; m1_addr = 30'h200;
        m0_access = 1; m1_access = 1;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b1 || bus_addr !== 30'h100) begin
            n_fail++; $display("FAIL first_grant: access=%b addr=%h expected 1/100", bus_access, bus_addr);
        end
        tick();
        slave_drive(0, 0, 32'h1111_0000);
        @(negedge clk);
        tick();
        slave_idle();
        m0_access = 0;
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b1 || bus_addr !== 30'h200) begin
            n_fail++; $display("FAIL no_bubble: access=%b addr=%h expected 1/200", bus_access, bus_addr);
        end
        tick();
        slave_drive(1, 0, 32'h2222_0000);
        @(negedge clk);
        tick();
        slave_idle();
        m1_access = 0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_back_to_back;
        int cnt0;
        int cnt1;
        int exp_m;
        cnt0 = 0; cnt1 = 0; exp_m = 0;
        m0_addr = 30'h300; m1_addr = 30'h301;
        m0_access = 1; m1_access = 1;
        tick();
        for (int i = 0; i < 6; i++) begin
            slave_drive(exp_m, 0, 32'hA000_0000 + i);
            if (i == 5) m0_access = 0;
            @(negedge clk);
            n_checks++;
            if (bus_access !== 1'b1 || bus_addr !== (exp_m == 0 ? 30'h300 : 30'h301)) begin
                n_fail++;
                $display("FAIL fair_grant %0d: access=%b addr=%h expected master %0d", i, bus_access, bus_addr, exp_m);
            end
            cnt0 += int'(m0_ack);
            cnt1 += int'(m1_ack);
            tick();
            exp_m ^= 1;
        end
        slave_idle();
        m1_access = 0;
        @(negedge clk);
        n_checks++;
        if (cnt0 != 3 || cnt1 != 3 || bus_access !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_count: acks %0d/%0d access=%b expected 3/3/0", cnt0, cnt1, bus_access);
        end
        tick();
    endtask

    task automatic test_write_error;
        m0_addr = 30'h3FFF_FFFF; m0_wr_val = 32'hFFFF_FFFF; m0_wr_en = 1; m0_bytesel = 4'hF;
        m1_addr = 30'h0ABC_DEF0; m1_wr_val = 32'h1234_5678; m1_wr_en = 1; m1_bytesel = 4'b0011;
        m1_access = 1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel} !==
            {1'b1, 30'h0ABC_DEF0, 32'h1234_5678, 1'b1, 4'b0011}) begin
            n_fail++;
            $display("FAIL write_route: addr=%h val=%h en=%b bsel=%b expected 0abcdef0/12345678/1/0011",
                     bus_addr, bus_wr_val, bus_wr_en, bus_bytesel);
        end
        tick();
        slave_drive(1, 1, 32'hBAD0_BAD0);
        @(negedge clk);
        tick();
        slave_idle();
        idle_masters();
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b0) begin
            n_fail++; $display("FAIL write_release: bus_access=%b expected 0", bus_access);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        m0_addr = 30'h55; m0_access = 1;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b1 || bus_addr !== 30'h55) begin
            n_fail++; $display("FAIL abort_grant: access=%b addr=%h expected 1/55", bus_access, bus_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        bus_ack  = 1'b1;
        bus_data = 32'h7777_0000;
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b0 || bus_addr !== 30'h0) begin
            n_fail++; $display("FAIL abort_idle: access=%b addr=%h expected 0/0", bus_access, bus_addr);
        end
        tick();
        rst = 1'b1;
        m0_access = 0;
        slave_idle();
        @(negedge clk);
        tick();
    endtask

    task automatic test_timeout;
`ifdef BUS_ARB_TIMEOUT_EN
        int hold = 8;
`else
        int hold = 20;
`endif
        m0_addr = 30'h66; m1_addr = 30'h77;
        m0_access = 1; m1_access = 1;
        tick();
        for (int k = 1; k <= hold; k++) begin
`ifdef BUS_ARB_TIMEOUT_EN
            if (k == hold) expect_resp(0, 1, 32'd0);
`endif
            @(negedge clk);
            n_checks++;
            if (bus_access !== 1'b1 || bus_addr !== 30'h66) begin
                n_fail++; $display("FAIL hold %0d: access=%b addr=%h expected 1/66", k, bus_access, bus_addr);
            end
            tick();
        end
`ifndef BUS_ARB_TIMEOUT_EN
        slave_drive(0, 0, 32'h6666_6666);
        @(negedge clk);
        tick();
        slave_idle();
`endif
        m0_access = 0;
        slave_drive(1, 0, 32'h7777_7777);
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b1 || bus_addr !== 30'h77) begin
            n_fail++; $display("FAIL handover: access=%b addr=%h expected 1/77", bus_access, bus_addr);
        end
        tick();
        slave_idle();
        m1_access = 0;
        @(negedge clk);
        n_checks++;
        if (bus_access !== 1'b0) begin
            n_fail++; $display("FAIL timeout_release: bus_access=%b expected 0", bus_access);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_masters();
        slave_idle();
        rst = 1'b0;
        #1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_write_error();
        test_reset_mid();
        test_timeout();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keynsham_bus_arbiter.md
Name: keynsham_bus_arbiter

Overview:
Two-master, one-slave bus arbiter that shares the peripheral bus, and so the timer block behind it, between a CPU data port (master 0) and a debug/DMA port (master 1).
- Round-robin arbitration with a registered grant.
- Forwards one transaction at a time.
- Routes ack, error and read data back only to the granted master.
- Sits between the masters and the peripheral blocks; bus chip-select decode stays downstream.

Parameters:
timeout_cycles, 255, cycles from grant to forced error; used only when BUS_ARB_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low (rst==0 resets on clk rising edge)
m0_access  input  1  master 0 request; held high until m0_ack or m0_error
m0_addr  input  30  master 0 word address
m0_wr_val  input  32  master 0 write data
m0_wr_en  input  1  master 0 write enable
m0_bytesel  input  4  master 0 byte lanes
m0_ack  output  1  master 0 completion pulse
m0_error  output  1  master 0 error pulse
m0_data  output  32  master 0 read data; zero unless m0_ack
m1_access, m1_addr, m1_wr_val, m1_wr_en, m1_bytesel  inputs  1/30/32/1/4  master 1 request signals, as for master 0
m1_ack, m1_error, m1_data  outputs  1/1/32  master 1 response signals, as for master 0
bus_access  output  1  slave access strobe
bus_addr  output  30  slave address
bus_wr_val  output  32  slave write data
bus_wr_en  output  1  slave write enable
bus_bytesel  output  4  slave byte lanes
bus_ack  input  1  slave completion
bus_error  input  1  slave error
bus_data  input  32  slave read data

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Registered `last` pointer holds the master granted most recently.
- Reset (rst==0): state=IDLE, last=1 (so master 0 wins first). All outputs read 0 in the cycle after reset.
- IDLE transitions:
  - only mX_access high: go to GNTX.
  - both high: grant the master != last.
  - neither high: stay in IDLE.
- Request latency: access seen in IDLE at edge N gives grant at N+1; bus_access is high in the cycle following N.
- GNTX outputs:
  - bus_access = mX_access.
  - bus_addr, bus_wr_val, bus_wr_en, bus_bytesel = master X values, combinational.
- Outside any grant: all bus_* outputs are 0.
- Responses:
  - mX_ack = bus_ack & GNTX; mX_error = bus_error & GNTX.
  - mX_data = (GNTX & bus_ack) ? bus_data : 0.
  - Non-granted master always sees ack=0, error=0, data=0.
- Completion (bus_ack | bus_error in GNTX): last<=X.
  - Other master requesting: go directly to its grant state (no IDLE bubble).
  - Otherwise: go to IDLE.
  - Same master re-requesting while the other waits is not regranted.
- Slave response outside a grant is ignored.
- Granted master drops access before a response (protocol violation): bus_access falls combinationally; FSM returns to IDLE next edge; last<=X.
- bus_ack and bus_error together: both forwarded; counts as one completion.
- Reset mid-transaction: grant dropped at that edge; no ack/error generated for the aborted access.
- Fairness: with both masters continuously requesting, grants alternate strictly 0,1,0,1.

Optional Feature:
BUS_ARB_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to GNTX and increments each granted cycle without a response.
  - When the count reaches timeout_cycles-1 with no bus_ack/bus_error, mX_error pulses for one cycle, the bus is released, and last<=X.
  - A response arriving in that same cycle wins: it is forwarded normally and no extra error is generated.
- Undefined: no counter; a grant is held until a response arrives or the master drops access.

Test Plan:
1. m0 read, addr 0x10; slave acks 2 cycles after bus_access with bus_data=0xDEADBEEF -> bus_access high from cycle after request; m0_ack one cycle with m0_data=0xDEADBEEF; m1_ack=0, m1_data=0.
2. After reset, m0 and m1 request in the same cycle -> m0 granted first; m1 granted in the cycle after m0_ack, with no idle bubble; bus_addr switches to m1_addr.
3. Both masters hold access for 6 transactions, slave acks in 1 cycle -> grant order 0,1,0,1,0,1; each master sees exactly 3 acks.
4. m1 write 0x12345678, bytesel=4'b0011; slave returns bus_error -> bus_wr_val/bus_bytesel match m1 inputs; m1_error pulses once, m1_data=0, m0 outputs 0.
5. rst driven low while in GNT0 before ack -> next cycle state IDLE, bus_access=0; late bus_ack produces no m0_ack.
6. With BUS_ARB_TIMEOUT_EN and timeout_cycles=8, slave never responds -> m0_error on the 8th granted cycle; a pending m1 is granted on the next edge. Without the macro, the grant is held indefinitely.
